// File: rtl/dut.sv
// Serial delay line with registered edge detection and a saturating rising-edge counter.
// Every output comes straight from a flop; edge flags are precomputed from the next o_data value.
module dut #(
  parameter int DEPTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_data,
  output logic             o_data,
  output logic             o_rise,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_count
);

  logic [DEPTH-1:0] stage_q, stage_d;
  logic             o_data_q;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] count_q, count_d;

  generate
    if (DEPTH == 1) begin : g_single
      assign stage_d = i_data;
    end else begin : g_multi
      assign stage_d = {stage_q[DEPTH-2:0], i_data};
    end
  endgenerate

  always_comb begin
    // Compare the value o_data is about to take with its current value, so the
    // pulse lands in the same cycle as the new o_data.
    rise_d  = stage_d[DEPTH-1] & ~stage_q[DEPTH-1];
    fall_d  = ~stage_d[DEPTH-1] & stage_q[DEPTH-1];
    count_d = count_q;
    // o_data & ~o_data_q is exactly the condition flagged by o_rise this cycle.
    if (stage_q[DEPTH-1] && !o_data_q && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q  <= '0;
      o_data_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      stage_q  <= stage_d;
      o_data_q <= stage_q[DEPTH-1];
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      count_q  <= count_d;
    end
  end

  assign o_data  = stage_q[DEPTH-1];
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_dut.sv
// Scoreboard bench: two instances (DEPTH=1/CNT_W=2 and DEPTH=4/CNT_W=8) share stimulus;
// expected outputs come from a sample-history model and are checked on the falling edge.
module tb_dut;

  logic       clk;
  logic       rst;
  logic       i_data;
  logic       d_a, r_a, f_a;
  logic [1:0] c_a;
  logic       d_b, r_b, f_b;
  logic [7:0] c_b;

  int n_checks = 0;
  int n_fail   = 0;

  dut #(.DEPTH(1), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .i_data(i_data),
    .o_data(d_a), .o_rise(r_a), .o_fall(f_a), .o_count(c_a)
  );

  dut #(.DEPTH(4), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .i_data(i_data),
    .o_data(d_b), .o_rise(r_b), .o_fall(f_b), .o_count(c_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int da, ra, fa, ca;
    int db, rb, fb, cb;
  } exp_t;

  exp_t sbq[$];

  // Reference model: samples taken since the last reset, newest at the back.
  bit hist[$];
  int prev_a = 0, prev_b = 0;
  int rises_a = 0, rises_b = 0;

  function automatic int sat(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic exp_t model(bit r, bit d);
    exp_t e;
    if (r) begin
      hist.delete();
      prev_a = 0; prev_b = 0;
      rises_a = 0; rises_b = 0;
      e = '{0, 0, 0, 0, 0, 0, 0, 0};
    end else begin
      hist.push_back(d);
      if (hist.size() > 4) void'(hist.pop_front());
      e.da = hist[hist.size()-1];
      e.db = (hist.size() >= 4) ? int'(hist[hist.size()-4]) : 0;
      e.ra = (e.da == 1 && prev_a == 0) ? 1 : 0;
      e.fa = (e.da == 0 && prev_a == 1) ? 1 : 0;
      e.rb = (e.db == 1 && prev_b == 0) ? 1 : 0;
      e.fb = (e.db == 0 && prev_b == 1) ? 1 : 0;
      e.ca = sat(rises_a, 3);
      e.cb = sat(rises_b, 255);
      rises_a += e.ra;
      rises_b += e.rb;
      prev_a = e.da;
      prev_b = e.db;
    end
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("a_data",  int'(d_a), e.da);
      chk("a_rise",  int'(r_a), e.ra);
      chk("a_fall",  int'(f_a), e.fa);
      chk("a_count", int'(c_a), e.ca);
      chk("a_excl",  int'(r_a & f_a), 0);
      chk("b_data",  int'(d_b), e.db);
      chk("b_rise",  int'(r_b), e.rb);
      chk("b_fall",  int'(f_b), e.fb);
      chk("b_count", int'(c_b), e.cb);
      chk("b_excl",  int'(r_b & f_b), 0);
    end
  end

  task automatic step(bit r, bit d);
    rst    = r;
    i_data = d;
    @(posedge clk);
    sbq.push_back(model(r, d));
    #1;
  endtask

  task automatic idle(int n, bit d);
    for (int i = 0; i < n; i++) step(1'b0, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    i_data = 1'b0;
    // Two reset edges, then a single-cycle pulse.
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(8, 1'b0);
    // Five isolated pulses: saturates the 2-bit counter.
    for (int p = 0; p < 5; p++) begin
      step(1'b0, 1'b1);
      idle(6, 1'b0);
    end
    // Hold 1, then reset mid-stream while still high.
    idle(10, 1'b1);
    step(1'b1, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 1'b0);
    idle(6, 1'b0);
    // Alternating pattern.
    for (int k = 0; k < 8; k++) step(1'b0, k[0] ? 1'b0 : 1'b1);
    idle(6, 1'b0);
    // Steady 1 after reset.
    step(1'b1, 1'b0);
    idle(10, 1'b1);
    idle(4, 1'b0);
    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
    end
    idle(5, 1'b0);
    @(negedge clk);
    #1;
    chk("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dut.md
DUT -- requirements
Module: dut

Interface
REQ-001 Parameter DEPTH, default 1, meaning number of register stages between i_data and o_data; legal range 1..16.
REQ-002 Parameter CNT_W, default 8, meaning width of the rising-edge counter o_count; legal range 1..32.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 i_data  input  1  serial data sample, sampled every rising clk edge.
REQ-007 o_data  output  1  i_data delayed by exactly DEPTH clock cycles, registered.
REQ-008 o_rise  output  1  one-cycle pulse: rising edge present on o_data this cycle.
REQ-009 o_fall  output  1  one-cycle pulse: falling edge present on o_data this cycle.
REQ-010 o_count  output  CNT_W  number of rising edges seen on o_data since reset, saturating.

Function
REQ-011 Delay line SHALL be a DEPTH-stage shift register: stage0 <= i_data, stage k <= stage k-1, o_data = last stage.
REQ-012 Latency SHALL be exactly DEPTH cycles: value of i_data sampled at edge N appears on o_data after edge N+DEPTH-1 (DEPTH=1: visible immediately after the sampling edge).
REQ-013 All outputs SHALL be driven directly from flip-flops; no combinational path from i_data to any output.
REQ-014 Module SHALL keep a registered copy o_data_q of o_data's previous-cycle value.
REQ-015 o_rise SHALL equal o_data AND NOT o_data_q, registered so it is high in the same cycle o_data first reads 1.
REQ-016 o_fall SHALL equal NOT o_data AND o_data_q, with the same timing as o_rise.
REQ-017 o_rise and o_fall SHALL never be high in the same cycle.
REQ-018 o_count SHALL increment by 1 in the cycle after each o_rise pulse.
REQ-019 o_count SHALL saturate at 2^CNT_W-1 and hold; no wrap-around.
REQ-020 A steady 1 or 0 on i_data SHALL produce no edge pulses after the line settles.
REQ-021 Alternating i_data (1,0,1,0...) SHALL produce alternating o_rise/o_fall pulses every cycle once propagated.

Reset
REQ-022 When rst=1 at a rising clk edge, all delay stages, o_data_q, o_data, o_rise, o_fall and o_count SHALL become 0 at that edge.
REQ-023 rst SHALL take priority over i_data; i_data sampled during reset is discarded.
REQ-024 Reset asserted mid-operation SHALL flush in-flight data; no edge pulse SHALL be generated by the reset-induced 1->0 transition of o_data.
REQ-025 After rst deasserts, the first i_data sample SHALL be the one taken at the first edge with rst=0.
REQ-026 Output values before the first reset are undefined; the bench SHALL reset before checking.

Verification
REQ-027 DEPTH=1: rst=1 for 2 edges, release, i_data=1 for one cycle -> o_data=1 for exactly one cycle right after the sampling edge, o_rise=1 in that cycle, o_fall=1 in the next, o_count=1.
REQ-028 DEPTH=4: single-cycle pulse on i_data -> o_data pulse appears 4 edges after sampling, width 1 cycle.
REQ-029 Reset mid-stream: i_data=1 held, then rst=1 for one edge -> all outputs 0 next cycle, o_fall stays 0, o_count=0.
REQ-030 CNT_W=2: 5 isolated i_data pulses -> o_count reads 1,2,3,3,3.
REQ-031 Alternating i_data for 8 cycles -> 4 o_rise and 4 o_fall pulses, never coincident.
REQ-032 Steady i_data=1 for 10 cycles after reset -> exactly one o_rise, o_count=1, o_data=1 throughout after latency.
